// File: rtl/trisc0_fetch_ctrl_pkg.sv
// trisc0_fetch_ctrl_pkg: constants and types shared across the TRISC0 fetch slice.
// These defaults must stay in sync with prog_rom and the decoder. The reset PC is
// the address fetched first once reset is released.
package trisc0_fetch_ctrl_pkg;

  localparam int unsigned TRISC0_DATA_WIDTH = 12;
  localparam int unsigned TRISC0_ADDR_WIDTH = 8;
  localparam int unsigned TRISC0_RESET_PC   = 0;

  // PRIME: the ROM output is not yet a valid instruction; RUN: instr is valid.
  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/trisc0_fetch_ctrl_if.sv
// trisc0_fetch_ctrl_if: fetch-side bus of the TRISC0 core. It carries the prog_rom
// address/data, the instruction handed to decode, and the decode-side redirect
// requests.
//   master : the fetch controller (drives rom_addr, instr*, stack_* flags)
//   slave  : ROM/decode side (drives rom_q, stall, jump, call, ret, jump_target)
interface trisc0_fetch_ctrl_if
  import trisc0_fetch_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = TRISC0_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = TRISC0_ADDR_WIDTH
);
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_q;
  logic [DATA_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_valid;
  logic                  stall;
  logic                  jump;
  logic                  call;
  logic                  ret;
  logic [ADDR_WIDTH-1:0] jump_target;
  logic                  stack_empty;
  logic                  stack_full;
  logic                  stack_err;

  modport master (
    output rom_addr, instr, instr_pc, instr_valid, stack_empty, stack_full, stack_err,
    input  rom_q, stall, jump, call, ret, jump_target
  );

  modport slave (
    input  rom_addr, instr, instr_pc, instr_valid, stack_empty, stack_full, stack_err,
    output rom_q, stall, jump, call, ret, jump_target
  );
endinterface

// File: rtl/trisc0_fetch_ctrl_ret_stack.sv
// trisc0_ret_stack: circular LIFO of return addresses.
//   clk, reset       : clock, synchronous active-high reset
//   push_i/push_data_i: push a return address (on full, the oldest entry is overwritten)
//   pop_i            : drop the top entry (no effect when empty)
//   top_o            : current top entry, 0 when empty
//   empty_o, full_o  : occupancy flags
//   ovf_o, unf_o     : single-cycle pulses for push-when-full / pop-when-empty
module trisc0_ret_stack
  import trisc0_fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = TRISC0_ADDR_WIDTH,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [ADDR_WIDTH-1:0] push_data_i,
  output logic [ADDR_WIDTH-1:0] top_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  ovf_o,
  output logic                  unf_o
);
  localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
  localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);

  logic [ADDR_WIDTH-1:0] mem_q [STACK_DEPTH];
  logic [PTR_W-1:0]      top_q, top_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(STACK_DEPTH));
  assign top_o   = empty_o ? '0 : mem_q[top_q];
  assign ovf_o   = push_i & full_o;
  assign unf_o   = pop_i & empty_o;

  // The top index wraps modulo the power-of-two depth, so a push when full
  // overwrites the oldest slot while the count saturates.
  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    if (push_i) begin
      top_d = top_q + 1'b1;
      if (!full_o) cnt_d = cnt_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      top_d = top_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !reset) mem_q[top_d] <= push_data_i;
  end
endmodule

// File: rtl/trisc0_fetch_ctrl.sv
// trisc0_fetch_ctrl: TRISC0 instruction fetch sequencer. Owns the PC, drives the
// prog_rom address (1-cycle registered ROM) and qualifies rom_q as instr.
// Redirects (jump/call/ret) cost no bubble since rom_addr is combinational.
//   clk, reset : clock, synchronous active-high reset (shared with prog_rom)
//   bus        : trisc0_fetch_ctrl_if.master (rom_addr/rom_q, instr/instr_pc/
//                instr_valid, stall/jump/call/ret/jump_target, stack flags)
// Build option: define TRISC0_STACK_ERR_EN for a sticky stack_err flag
// (push-when-full or pop-when-empty); otherwise stack_err is tied low.
module trisc0_fetch_ctrl
  import trisc0_fetch_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = TRISC0_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = TRISC0_ADDR_WIDTH,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  trisc0_fetch_ctrl_if.master bus
);
  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [ADDR_WIDTH-1:0] ret_addr;
  logic                  push, pop;
  logic                  ovf, unf;

  trisc0_ret_stack #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (pc_q + 1'b1),
    .top_o       (ret_addr),
    .empty_o     (bus.stack_empty),
    .full_o      (bus.stack_full),
    .ovf_o       (ovf),
    .unf_o       (unf)
  );

  // Next-address mux; priority: prime, stall, jump, call, ret, sequential.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (reset) begin
      addr_d  = '0;
    end else if (state_q == ST_PRIME) begin
      state_d = ST_RUN;
    end else if (!bus.stall) begin
      if (bus.jump) begin
        addr_d = bus.jump_target;
      end else if (bus.call) begin
        push   = 1'b1;
        addr_d = bus.jump_target;
      end else if (bus.ret) begin
        pop    = 1'b1;
        addr_d = ret_addr;
      end else begin
        addr_d = pc_q + 1'b1;
      end
      pc_d = addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_PRIME;
      pc_q    <= ADDR_WIDTH'(TRISC0_RESET_PC);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.rom_addr    = addr_d;
  assign bus.instr       = bus.rom_q;
  assign bus.instr_pc    = pc_q;
  assign bus.instr_valid = (state_q == ST_RUN);

`ifdef TRISC0_STACK_ERR_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (reset)           err_q <= 1'b0;
    else if (ovf || unf) err_q <= 1'b1;
  end
  assign bus.stack_err = err_q;
`else
  logic unused_fault;
  assign unused_fault  = ovf | unf;
  assign bus.stack_err = 1'b0;
`endif
endmodule
